ir_code_receiver: RTL and testbench
===================================

# ir_code_receiver

Decodes NEC-format infrared frames from a demodulated IR receiver module (TSOP-style, active-low output) into 32-bit codes. It is the receive-side counterpart of the TV-B-Gone transmitter. It is used to capture and check the codes the transmitter emits, and to learn codes from real remotes. It runs on the 8 MHz system clock and presents decoded codes, status pulses and a debug state vector to the top level.

## Interface
- `CLK_HZ`, 8_000_000, system clock frequency.
- `TICK_HZ`, 100_000, measurement timebase (10 µs tick); prescale = CLK_HZ/TICK_HZ.
- `IR_ACTIVE_LOW`, 1, 1 means a mark (carrier present) is `ir_in` = 0.
- `clock_in`  in  1  system clock; all logic is on its rising edge.
- `resetn_in`  in  1  asynchronous active-low reset.
- `ir_in`  in  1  raw demodulated IR pin, asynchronous to `clock_in`.
- `code_out`  out  32  last decoded frame; first received bit is in bit 0.
- `valid_out`  out  1  one-cycle pulse when a full frame has been decoded.
- `repeat_out`  out  1  one-cycle pulse when a repeat frame has been decoded.
- `check_ok_out`  out  1  high when `code_out[15:8]` == ~`code_out[7:0]` and `code_out[31:24]` == ~`code_out[23:16]`.
- `error_out`  out  1  one-cycle pulse on timing violation or timeout.
- `busy_out`  out  1  high whenever the state is not IDLE.
- `state`  out  4  debug: current state encoding.

## Operation
- Synchronizer: two flops on `ir_in`, then polarity normalization to `mark` (1 = carrier). An edge detector produces `mark_start` and `mark_end`.
- Duration counter:
  - Counts ticks since the last edge.
  - Clears on every edge.
  - Saturates at 2047.
  - The prescaler also clears on every edge.
- Windows, in ticks, inclusive:
  - Leader mark: 800–1000.
  - Leader space: 400–500.
  - Repeat space: 190–260.
  - Bit/stop mark: 40–72.
  - Space "0": 40–72.
  - Space "1": 140–200.
  - Timeout: 1200.
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_STOP.
  - IDLE: `mark_start` → LEAD_MARK.
  - LEAD_MARK: on `mark_end`, if the mark is in the leader window → LEAD_SPACE, else error.
  - LEAD_SPACE: on `mark_start`:
    - leader-space window → BIT_MARK, with bit index = 0;
    - repeat-space window → REP_STOP;
    - otherwise error.
  - BIT_MARK: on `mark_end`, if the mark is in the bit window → BIT_SPACE, else error.
  - BIT_SPACE: on `mark_start`, classify the space as 0 or 1 and shift it into the shift register at the current bit index.
    - After index 31 → STOP_MARK.
    - Otherwise increment the index → BIT_MARK.
    - A space in neither window is an error.
  - STOP_MARK: on `mark_end` with the mark in the bit window:
    - load `code_out` from the shift register;
    - pulse `valid_out`;
    - set the internal `have_code` flag;
    - → IDLE.
  - REP_STOP: on `mark_end` with the mark in the bit window:
    - if `have_code` is set, pulse `repeat_out`; otherwise pulse `error_out`;
    - → IDLE.
- Error handling:
  - Any error pulses `error_out` for one cycle.
  - If the error was detected on a `mark_start`, the next state is LEAD_MARK, so a new frame is not lost. Otherwise the next state is IDLE.
- Timeout: in any state other than IDLE, the counter reaching 1200 pulses `error_out` → IDLE.
- `code_out` and `check_ok_out` hold their value until the next valid frame. Neither an error nor a repeat frame changes them.

## Timing
- Reset values:
  - `code_out` = 0.
  - `check_ok_out` = 0.
  - All pulse outputs = 0.
  - `busy_out` = 0.
  - `state` = IDLE (0).
  - `have_code` = 0.
  - Counter and prescaler = 0.
- Latency: a raw pin edge reaches the edge detector after 2 clocks. Outputs update on the following clock, 3 clocks after the pin edge.
- Pulses are exactly one cycle wide. `valid_out`, `repeat_out` and `error_out` are never high together.
- An edge that arrives in the same cycle as the timeout is processed as an edge; the edge takes priority.
- Reset asserted mid-frame returns the block to the full reset state immediately. A partial frame is discarded.
- Glitches shorter than 40 ticks fail the windows and produce `error_out`.

## Structure
- Package `ir_rx_pkg` holds:
  - the state enum (4-bit);
  - all window and timeout constants in ticks;
  - the `NEC_BITS` = 32 constant.
- Sub-module `ir_pulse_timer` contains the prescaler, the saturating 11-bit tick counter with clear-on-edge, and the `timeout` flag.
- The top `ir_code_receiver` contains the synchronizer, the edge detector, the FSM, the shift register and the output registers.

## Test plan
- Full frame, address 0x04, command 0x08: 9 ms mark, 4.5 ms space, then 32 bits LSB-first of 0x04, 0xFB, 0x08, 0xF7, then the stop mark → one `valid_out` pulse, `code_out` = 0xF708FB04, `check_ok_out` = 1.
- Repeat frame after the frame above: 9 ms mark, 2.25 ms space, 562 µs mark → `repeat_out` pulse, `code_out` unchanged. The same repeat frame right after reset → `error_out`, no `repeat_out`.
- Corrupted inverse byte, frame 0x0708FB04 → `valid_out` pulse, `check_ok_out` = 0.
- Bit 10 space stretched to 3 ms → `error_out` pulse, state IDLE, `code_out` retains its previous value. A valid frame immediately after decodes correctly.
- Frame truncated after 20 bits with the line idle → `error_out` 1200 ticks (±1) after the last edge, `busy_out` drops.
- `resetn_in` pulsed low during bit 16 → all outputs return to their reset values. A following full frame decodes to the expected code.

Source files
------------

// File: rtl/ir_rx_pkg.sv
// Shared types and timing constants for the NEC infrared receiver.
// Every duration here is counted in measurement ticks.
package ir_rx_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LEAD_MARK  = 4'd1,
    S_LEAD_SPACE = 4'd2,
    S_BIT_MARK   = 4'd3,
    S_BIT_SPACE  = 4'd4,
    S_STOP_MARK  = 4'd5,
    S_REP_STOP   = 4'd6
  } ir_state_e;

  localparam int CNT_W          = 11;
  localparam int CNT_MAX        = 2047;
  localparam int LEAD_MARK_MIN  = 800;
  localparam int LEAD_MARK_MAX  = 1000;
  localparam int LEAD_SPACE_MIN = 400;
  localparam int LEAD_SPACE_MAX = 500;
  localparam int REP_SPACE_MIN  = 190;
  localparam int REP_SPACE_MAX  = 260;
  localparam int BIT_MARK_MIN   = 40;
  localparam int BIT_MARK_MAX   = 72;
  localparam int SPACE0_MIN     = 40;
  localparam int SPACE0_MAX     = 72;
  localparam int SPACE1_MIN     = 140;
  localparam int SPACE1_MAX     = 200;
  localparam int TIMEOUT_TICKS  = 1200;
  localparam int NEC_BITS       = 32;
  localparam int IDX_W          = 5;

  function automatic logic in_win(input logic [CNT_W-1:0] d, input int lo, input int hi);
    return (int'(d) >= lo) && (int'(d) <= hi);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Measures the time since the last line edge in 10 us ticks.
// The tick counter saturates, and the prescaler restarts on every edge.
module ir_pulse_timer
  import ir_rx_pkg::*;
#(
  parameter int CLK_HZ  = 8_000_000,
  parameter int TICK_HZ = 100_000
) (
  input  logic             clock_in,
  input  logic             resetn_in,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_timeout
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    r_presc;
  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));

  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_count != CNT_W'(CNT_MAX)) r_count <= r_count + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_timeout = (r_count >= CNT_W'(TIMEOUT_TICKS));

endmodule

// File: rtl/ir_code_receiver.sv
// NEC infrared frame decoder: synchronizes the demodulated pin, times marks
// and spaces, and assembles 32-bit codes (first received bit in bit 0).
module ir_code_receiver
  import ir_rx_pkg::*;
#(
  parameter int CLK_HZ        = 8_000_000,
  parameter int TICK_HZ       = 100_000,
  parameter int IR_ACTIVE_LOW = 1
) (
  input  logic        clock_in,
  input  logic        resetn_in,
  input  logic        ir_in,
  output logic [31:0] code_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        check_ok_out,
  output logic        error_out,
  output logic        busy_out,
  output logic [3:0]  state
);

  // Idle line level; the synchronizer resets to it so reset never fakes an edge.
  localparam logic IDLE_LVL = (IR_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             r_sync1, r_sync2, r_mark_d;
  logic             w_mark, w_mark_start, w_mark_end, w_edge;
  logic [CNT_W-1:0] w_count;
  logic             w_timeout;

  ir_state_e        r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_shift, r_code;
  logic             r_have_code, r_valid, r_repeat, r_error;
  logic             w_valid, w_repeat, w_error, w_shift_en, w_bit;
  logic             w_idx_clr, w_idx_inc, w_load;

  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_sync1  <= IDLE_LVL;
      r_sync2  <= IDLE_LVL;
      r_mark_d <= 1'b0;
    end else begin
      r_sync1  <= ir_in;
      r_sync2  <= r_sync1;
      r_mark_d <= w_mark;
    end
  end

  assign w_mark       = r_sync2 ^ IDLE_LVL;
  assign w_mark_start = w_mark & ~r_mark_d;
  assign w_mark_end   = ~w_mark & r_mark_d;
  assign w_edge       = w_mark_start | w_mark_end;

  ir_pulse_timer #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_timer (
    .clock_in  (clock_in),
    .resetn_in (resetn_in),
    .i_clear   (w_edge),
    .o_count   (w_count),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Errors seen on a mark start go to LEAD_MARK so that mark can open a new frame.
  always_comb begin
    w_next     = r_state;
    w_valid    = 1'b0;
    w_repeat   = 1'b0;
    w_error    = 1'b0;
    w_shift_en = 1'b0;
    w_bit      = 1'b0;
    w_idx_clr  = 1'b0;
    w_idx_inc  = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: if (w_mark_start) w_next = S_LEAD_MARK;
      S_LEAD_MARK: if (w_mark_end) begin
        if (in_win(w_count, LEAD_MARK_MIN, LEAD_MARK_MAX)) w_next = S_LEAD_SPACE;
        else begin w_error = 1'b1; w_next = S_IDLE; end
      end
      S_LEAD_SPACE: if (w_mark_start) begin
        if (in_win(w_count, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
          w_next    = S_BIT_MARK;
          w_idx_clr = 1'b1;
        end else if (in_win(w_count, REP_SPACE_MIN, REP_SPACE_MAX)) w_next = S_REP_STOP;
        else begin w_error = 1'b1; w_next = S_LEAD_MARK; end
      end
      S_BIT_MARK: if (w_mark_end) begin
        if (in_win(w_count, BIT_MARK_MIN, BIT_MARK_MAX)) w_next = S_BIT_SPACE;
        else begin w_error = 1'b1; w_next = S_IDLE; end
      end
      S_BIT_SPACE: if (w_mark_start) begin
        if (in_win(w_count, SPACE0_MIN, SPACE0_MAX) || in_win(w_count, SPACE1_MIN, SPACE1_MAX)) begin
          w_shift_en = 1'b1;
          w_bit      = in_win(w_count, SPACE1_MIN, SPACE1_MAX);
          if (r_idx == IDX_W'(NEC_BITS - 1)) w_next = S_STOP_MARK;
          else begin w_idx_inc = 1'b1; w_next = S_BIT_MARK; end
        end else begin w_error = 1'b1; w_next = S_LEAD_MARK; end
      end
      S_STOP_MARK: if (w_mark_end) begin
        if (in_win(w_count, BIT_MARK_MIN, BIT_MARK_MAX)) begin
          w_load  = 1'b1;
          w_valid = 1'b1;
        end else w_error = 1'b1;
        w_next = S_IDLE;
      end
      S_REP_STOP: if (w_mark_end) begin
        if (in_win(w_count, BIT_MARK_MIN, BIT_MARK_MAX) && r_have_code) w_repeat = 1'b1;
        else w_error = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (!w_edge && (r_state != S_IDLE) && w_timeout) begin
      w_error    = 1'b1;
      w_shift_en = 1'b0;
      w_next     = S_IDLE;
    end
  end

  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_idx       <= '0;
      r_shift     <= '0;
      r_code      <= '0;
      r_have_code <= 1'b0;
      r_valid     <= 1'b0;
      r_repeat    <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid  <= w_valid;
      r_repeat <= w_repeat;
      r_error  <= w_error;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (w_shift_en) r_shift[r_idx] <= w_bit;
      if (w_load) begin
        r_code      <= r_shift;
        r_have_code <= 1'b1;
      end
    end
  end

  assign code_out     = r_code;
  assign check_ok_out = (r_code[15:8] == ~r_code[7:0]) && (r_code[31:24] == ~r_code[23:16]);
  assign valid_out    = r_valid;
  assign repeat_out   = r_repeat;
  assign error_out    = r_error;
  assign busy_out     = (r_state != S_IDLE);
  assign state        = r_state;

endmodule

// File: tb/tb_ir_code_receiver.sv
// Randomized NEC frame bench for ir_code_receiver against a frame-level model.
`timescale 1ns/1ps
module tb_ir_code_receiver;

  localparam int P       = 1;
  localparam int TICK_HZ = 100_000;
  localparam int CLK_HZ  = TICK_HZ * P;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ir_in = 1'b1;
  logic [31:0] code_out;
  logic        valid_out, repeat_out, check_ok_out, error_out, busy_out;
  logic [3:0]  state;

  ir_code_receiver #(
    .CLK_HZ        (CLK_HZ),
    .TICK_HZ       (TICK_HZ),
    .IR_ACTIVE_LOW (1)
  ) dut (
    .clock_in     (clk),
    .resetn_in    (resetn),
    .ir_in        (ir_in),
    .code_out     (code_out),
    .valid_out    (valid_out),
    .repeat_out   (repeat_out),
    .check_ok_out (check_ok_out),
    .error_out    (error_out),
    .busy_out     (busy_out),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse observer: counts the three status pulses and checks they stay one cycle and exclusive.
  int     n_valid = 0, n_rep = 0, n_err = 0;
  longint cyc = 0, last_err_cyc = 0;
  logic   prev_any = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (valid_out | repeat_out | error_out) begin
      chk("pulse_excl", int'(valid_out) + int'(repeat_out) + int'(error_out), 1);
      chk("pulse_width", {31'b0, prev_any}, 0);
    end
    if (valid_out)  n_valid <= n_valid + 1;
    if (repeat_out) n_rep   <= n_rep + 1;
    if (error_out) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
    end
    prev_any <= valid_out | repeat_out | error_out;
  end

  // Frame-level reference: last decoded code and whether any code has been seen.
  logic [31:0] m_code = '0;
  logic        m_have = 1'b0;
  int          v0, r0, e0;

  function automatic logic exp_ok(input logic [31:0] c);
    return (c[15:8] == ~c[7:0]) && (c[31:24] == ~c[23:16]);
  endfunction

  function automatic logic [31:0] nec_word(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  task automatic seg(input logic mark, input int ticks);
    ir_in = mark ? 1'b0 : 1'b1;
    repeat (ticks * P) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] code, input int nbits, input int stretch_at,
                            input bit final_mark);
    seg(1'b1, $urandom_range(810, 850));
    seg(1'b0, $urandom_range(410, 440));
    for (int i = 0; i < nbits; i++) begin
      seg(1'b1, $urandom_range(44, 68));
      if (i == stretch_at) seg(1'b0, 300);
      else if (code[i])    seg(1'b0, $urandom_range(144, 170));
      else                 seg(1'b0, $urandom_range(44, 68));
    end
    if (final_mark) seg(1'b1, $urandom_range(44, 68));
    ir_in = 1'b1;
  endtask

  task automatic send_repeat();
    seg(1'b1, $urandom_range(810, 850));
    seg(1'b0, $urandom_range(195, 255));
    seg(1'b1, $urandom_range(44, 68));
    ir_in = 1'b1;
  endtask

  task automatic snap();
    v0 = n_valid; r0 = n_rep; e0 = n_err;
  endtask

  task automatic expect_after(input string tag, input int dv, input int dr, input int de);
    seg(1'b0, 40);
    chk({tag, "_valid"}, n_valid - v0, dv);
    chk({tag, "_repeat"}, n_rep - r0, dr);
    chk({tag, "_error"}, n_err - e0, de);
    chk({tag, "_code"}, code_out, m_code);
    chk({tag, "_chkok"}, {31'b0, check_ok_out}, {31'b0, exp_ok(m_code)});
    chk({tag, "_busy"}, {31'b0, busy_out}, 0);
    chk({tag, "_state"}, {28'b0, state}, 0);
  endtask

  initial begin
    logic [31:0] c;
    longint      t0;
    int          es;
    logic        in_range;

    repeat (3) @(negedge clk);
    chk("rst_code", code_out, 0);
    chk("rst_chkok", {31'b0, check_ok_out}, 0);
    chk("rst_pulses", {29'b0, valid_out, repeat_out, error_out}, 0);
    chk("rst_busy", {31'b0, busy_out}, 0);
    chk("rst_state", {28'b0, state}, 0);
    resetn = 1'b1;
    seg(1'b0, 20);

    // Repeat with no code learned yet is an error.
    snap(); send_repeat(); expect_after("rep_nocode", 0, 0, 1);

    c = 32'hF708FB04;
    snap(); send_frame(c, 32, -1, 1); m_code = c; m_have = 1'b1;
    expect_after("frame_fixed", 1, 0, 0);
    chk("frame_fixed_ok", {31'b0, check_ok_out}, 1);

    snap(); send_repeat(); expect_after("rep_ok", 0, m_have ? 1 : 0, m_have ? 0 : 1);

    c = 32'h0708FB04;
    snap(); send_frame(c, 32, -1, 1); m_code = c;
    expect_after("frame_corrupt", 1, 0, 0);
    chk("frame_corrupt_ok", {31'b0, check_ok_out}, 0);

    c = nec_word(8'($urandom), 8'($urandom));
    snap(); send_frame(c, 32, -1, 1); m_code = c;
    expect_after("frame_rand1", 1, 0, 0);

    // Stretched bit-10 space errors at its mark start; that short mark then fails as a leader.
    c = nec_word(8'($urandom), 8'($urandom));
    snap(); send_frame(c, 11, 10, 1);
    expect_after("stretch", 0, 0, 2);

    c = nec_word(8'($urandom), 8'($urandom));
    snap(); send_frame(c, 32, -1, 1); m_code = c;
    expect_after("frame_rand2", 1, 0, 0);

    c = $urandom;
    snap(); send_frame(c, 20, -1, 1);
    t0 = cyc; es = n_err;
    for (int k = 0; k < 1300 * P && n_err == es; k++) @(negedge clk);
    @(negedge clk);
    in_range = ((last_err_cyc - t0) >= longint'(1199 * P + 2)) &&
               ((last_err_cyc - t0) <= longint'(1201 * P + 6));
    chk("timeout_seen", n_err - es, 1);
    chk("timeout_latency", {31'b0, in_range}, 1);
    expect_after("truncated", 0, 0, 1);

    c = nec_word(8'($urandom), 8'($urandom));
    send_frame(c, 16, -1, 0);
    seg(1'b1, 20);
    ir_in = 1'b1;
    resetn = 1'b0;
    #1;
    chk("midrst_code", code_out, 0);
    chk("midrst_chkok", {31'b0, check_ok_out}, 0);
    chk("midrst_busy", {31'b0, busy_out}, 0);
    chk("midrst_state", {28'b0, state}, 0);
    chk("midrst_pulses", {29'b0, valid_out, repeat_out, error_out}, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    m_code = '0; m_have = 1'b0;
    seg(1'b0, 20);

    snap(); send_repeat(); expect_after("rep_after_rst", 0, m_have ? 1 : 0, m_have ? 0 : 1);

    c = nec_word(8'($urandom), 8'($urandom));
    snap(); send_frame(c, 32, -1, 1); m_code = c; m_have = 1'b1;
    expect_after("frame_after_rst", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
